// File: rtl/press_pattern_gen.sv
// press_pattern_gen: emits N active-low button presses of fixed width separated
// by fixed gaps, followed by a cooldown, under a start/busy/done handshake.
//
// Handshake: start is a single-cycle request honoured only in IDLE (and only
// when abort is low); busy is high for every cycle a sequence occupies the
// line; done pulses for exactly one cycle on the first IDLE cycle after a
// normal completion (or the cycle after a zero-count request). abort ends a
// running sequence without a done pulse.
module press_pattern_gen #(
  parameter int PULSE_CYC    = 1600000,
  parameter int GAP_CYC      = 3200000,
  parameter int COOLDOWN_CYC = 8000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] count,
  input  logic       abort,
  output logic       nbtn_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] presses_left,
  output logic [1:0] dbg_state
);

  localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_PG > COOLDOWN_CYC) ? MAX_PG : COOLDOWN_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] COOL_LAST  = TW'(COOLDOWN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    GAP      = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    left_q, left_d;
  logic          nbtn_q, nbtn_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state, timer and press-count logic; outputs decode from next state
  // so every output is a flop with no combinational path to the pins.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    left_d  = left_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort has priority over start in IDLE: the request is dropped.
        if (start && !abort) begin
          if (count != 3'd0) begin
            left_d  = count;
            timer_d = '0;
            state_d = PRESS;
          end else begin
            // Nothing to press: acknowledge immediately.
            done_d = 1'b1;
          end
        end
      end

      PRESS: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
          left_d  = 3'd0;
        end else if (timer_q == PULSE_LAST) begin
          left_d  = left_q - 3'd1;
          timer_d = '0;
          state_d = (left_q == 3'd1) ? COOLDOWN : GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
          left_d  = 3'd0;
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = PRESS;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      COOLDOWN: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
          left_d  = 3'd0;
        end else if (timer_q == COOL_LAST) begin
          timer_d = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
        left_d  = 3'd0;
      end
    endcase

    // The line is low only while pressing; busy covers every non-IDLE state.
    nbtn_d = (state_d != PRESS);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset forces the line released mid-sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      left_q  <= 3'd0;
      nbtn_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      nbtn_q  <= nbtn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign nbtn_out     = nbtn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign presses_left = left_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_press_pattern_gen.sv
// Directed bench for press_pattern_gen with PULSE=4, GAP=3, COOLDOWN=5.
// Cycle c is the interval ending at edge c; inputs set in cycle c are sampled
// at that edge, and outputs read in cycle c were set by edge c-1.
module tb_press_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] count;
  logic       abort;
  logic       nbtn_out;
  logic       busy;
  logic       done;
  logic [2:0] presses_left;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  press_pattern_gen #(
    .PULSE_CYC   (4),
    .GAP_CYC     (3),
    .COOLDOWN_CYC(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .count       (count),
    .abort       (abort),
    .nbtn_out    (nbtn_out),
    .busy        (busy),
    .done        (done),
    .presses_left(presses_left),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit in_r(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // driver: inputs presented during cycle c of test id
  task automatic drive(input int id, input int c);
    start = 1'b0; count = 3'd0; abort = 1'b0; rst = 1'b0;
    case (id)
      1: if (c == 0) begin start = 1'b1; count = 3'd3; end
      2: begin
        if (c == 0)  begin start = 1'b1; count = 3'd1; end
        if (c == 10) begin start = 1'b1; count = 3'd2; end
      end
      3: if (c == 0) begin start = 1'b1; count = 3'd0; end
      4: begin
        if (c == 0) begin start = 1'b1; count = 3'd3; end
        if (c == 6) begin start = 1'b1; count = 3'd7; end
        if (c == 9) abort = 1'b1;
      end
      5: begin
        if (c == 0) begin start = 1'b1; count = 3'd2; end
        if (c == 2) rst = 1'b1;
        if (c == 5) begin start = 1'b1; count = 3'd2; end
      end
      6: if (c == 0) begin start = 1'b1; count = 3'd3; abort = 1'b1; end
      default: ;
    endcase
  endtask

  // hand-derived expectations for cycle c of test id
  task automatic expect_at(input int id, input int c,
                           output bit e_low, output bit e_busy,
                           output bit e_done, output int e_left);
    e_low = 0; e_busy = 0; e_done = 0; e_left = 0;
    case (id)
      1: begin
        e_low  = in_r(c,1,4) || in_r(c,8,11) || in_r(c,15,18);
        e_busy = in_r(c,1,23);
        e_done = (c == 24);
        e_left = in_r(c,1,4) ? 3 : in_r(c,5,11) ? 2 : in_r(c,12,18) ? 1 : 0;
      end
      2: begin
        e_low  = in_r(c,1,4) || in_r(c,11,14) || in_r(c,18,21);
        e_busy = in_r(c,1,9) || in_r(c,11,26);
        e_done = (c == 10) || (c == 27);
        e_left = in_r(c,1,4) ? 1 : in_r(c,11,14) ? 2 : in_r(c,15,21) ? 1 : 0;
      end
      3: e_done = (c == 1);
      4: begin
        e_low  = in_r(c,1,4) || in_r(c,8,9);
        e_busy = in_r(c,1,9);
        e_left = in_r(c,1,4) ? 3 : in_r(c,5,9) ? 2 : 0;
      end
      5: begin
        e_low  = in_r(c,1,2) || in_r(c,6,9) || in_r(c,13,16);
        e_busy = in_r(c,1,2) || in_r(c,6,21);
        e_done = (c == 22);
        e_left = in_r(c,1,2) ? 2 : in_r(c,6,9) ? 2 : in_r(c,10,16) ? 1 : 0;
      end
      default: ;
    endcase
  endtask

  // run one directed test for ncyc cycles, checking every output each cycle
  task automatic run_test(input int id, input int ncyc);
    bit e_low, e_busy, e_done;
    int e_left;
    for (int c = 0; c < ncyc; c++) begin
      drive(id, c);
      expect_at(id, c, e_low, e_busy, e_done, e_left);
      check($sformatf("t%0d c%0d nbtn_out", id, c), int'(nbtn_out), int'(!e_low));
      check($sformatf("t%0d c%0d busy", id, c), int'(busy), int'(e_busy));
      check($sformatf("t%0d c%0d done", id, c), int'(done), int'(e_done));
      check($sformatf("t%0d c%0d presses_left", id, c), int'(presses_left), e_left);
      if (done) begin
        if (exp_q.size() == 0) check($sformatf("t%0d unexpected done", id), c, -1);
        else check($sformatf("t%0d done cycle", id), c, int'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("t%0d missing done", id), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = 3'd0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset nbtn_out", int'(nbtn_out), 1);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset presses_left", int'(presses_left), 0);
    check("reset state", int'(dbg_state), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_q.push_back(24);
    run_test(1, 28);
    exp_q.push_back(10); exp_q.push_back(27);
    run_test(2, 30);
    exp_q.push_back(1);
    run_test(3, 4);
    run_test(4, 40);
    exp_q.push_back(22);
    run_test(5, 25);
    run_test(6, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
